id_ex_stage: RTL and testbench

//  ID/EX pipeline stage directly downstream of the control unit. Registers the decoded control

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_hazard.sv | 30 +++
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the packed control bundle for the ID/EX pipeline stage.
package id_ex_stage_pkg;

    // ALU operation select driven by the control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    // Write-back source select (memtoReg2)
    localparam logic [1:0] WB_SEL_MEM_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_AUIPC   = 2'b01;
    localparam logic [1:0] WB_SEL_LINK    = 2'b10;
    localparam logic [1:0] WB_SEL_LUI     = 2'b11;

    // Width of the control bundle below (valid is tracked separately)
    localparam int CTRL_W = 9;

    // Control bundle carried from ID into EX; all-zero is the bubble encoding
    typedef struct packed {
        logic       mem_read;
        logic       memto_reg1;
        logic [1:0] memto_reg2;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector: flags an instruction in ID that reads the
// destination of a load currently sitting in EX. Purely combinational.
module hazard_detect_unit
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_alu_src_i,
    input  logic       id_mem_write_i,
    output logic       stall_o
);

    logic use_rs2_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // rs2 is a real source for R-type, branch and store; x0 is never a hazard
    always_comb begin
        use_rs2_s = ~id_alu_src_i | id_mem_write_i;
        rs1_hit_s = (ex_rd_i == id_rs1_i);
        rs2_hit_s = use_rs2_s & (ex_rd_i == id_rs2_i);
        stall_o   = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
                    (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and a
// saturating bubble counter for performance debug.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_memRead,
    input  logic             id_memtoReg1,
    input  logic [1:0]       id_memtoReg2,
    input  logic [1:0]       id_ALUop,
    input  logic             id_memWrite,
    input  logic             id_ALUsrc,
    input  logic             id_regWrite,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ex_valid,
    output logic             ex_memRead,
    output logic             ex_memtoReg1,
    output logic [1:0]       ex_memtoReg2,
    output logic [1:0]       ex_ALUop,
    output logic             ex_memWrite,
    output logic             ex_ALUsrc,
    output logic             ex_regWrite,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t             id_ctrl_s;
    ctrl_t             ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [XLEN-1:0]   pc_d, pc_q;
    logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
    logic [XLEN-1:0]   imm_d, imm_q;
    logic [4:0]        rs1_d, rs1_q;
    logic [4:0]        rs2_d, rs2_q;
    logic [4:0]        rd_d, rd_q;
    logic [2:0]        funct3_d, funct3_q;
    logic              funct7b5_d, funct7b5_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              stall_s;
    logic              bubble_s;

    hazard_detect_unit u_hazard (
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_rd_i        (rd_q),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_alu_src_i   (id_ALUsrc),
        .id_mem_write_i (id_memWrite),
        .stall_o        (stall_s)
    );

    // Pack incoming control; flush overrides stall so upstream can redirect
    always_comb begin
        id_ctrl_s = '{mem_read:   id_memRead,
                      memto_reg1: id_memtoReg1,
                      memto_reg2: id_memtoReg2,
                      alu_op:     id_ALUop,
                      mem_write:  id_memWrite,
                      alu_src:    id_ALUsrc,
                      reg_write:  id_regWrite};
        bubble_s   = flush | stall_s;
        pc_write   = flush | ~stall_s;
        ifid_write = flush | ~stall_s;
    end

    // Next EX contents: zero on a bubble, otherwise ID with controls gated by id_valid
    always_comb begin
        valid_d    = 1'b0;
        ctrl_d     = '0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = 5'd0;
        rs2_d      = 5'd0;
        rd_d       = 5'd0;
        funct3_d   = 3'd0;
        funct7b5_d = 1'b0;
        if (!bubble_s) begin
            valid_d    = id_valid;
            ctrl_d     = id_valid ? id_ctrl_s : '0;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            funct3_d   = id_funct3;
            funct7b5_d = id_funct7b5;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Bubble counter: one per stall/flush cycle, holds at all-ones
    always_comb begin
        if (bubble_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline register; reset clears to the bubble encoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_memRead   = ctrl_q.mem_read;
    assign ex_memtoReg1 = ctrl_q.memto_reg1;
    assign ex_memtoReg2 = ctrl_q.memto_reg2;
    assign ex_ALUop     = ctrl_q.alu_op;
    assign ex_memWrite  = ctrl_q.mem_write;
    assign ex_ALUsrc    = ctrl_q.alu_src;
    assign ex_regWrite  = ctrl_q.reg_write;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_funct3    = funct3_q;
    assign ex_funct7b5  = funct7b5_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (built with a 4-bit bubble counter).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_memRead, id_memtoReg1, id_memWrite, id_ALUsrc, id_regWrite;
    logic [1:0]  id_memtoReg2, id_ALUop;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, flush;
    logic        pc_write, ifid_write;
    logic        ex_valid, ex_memRead, ex_memtoReg1, ex_memWrite, ex_ALUsrc, ex_regWrite;
    logic [1:0]  ex_memtoReg2, ex_ALUop;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [3:0]  bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_memRead(id_memRead),
        .id_memtoReg1(id_memtoReg1), .id_memtoReg2(id_memtoReg2), .id_ALUop(id_ALUop),
        .id_memWrite(id_memWrite), .id_ALUsrc(id_ALUsrc), .id_regWrite(id_regWrite),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .pc_write(pc_write), .ifid_write(ifid_write),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memtoReg1(ex_memtoReg1),
        .ex_memtoReg2(ex_memtoReg2), .ex_ALUop(ex_ALUop), .ex_memWrite(ex_memWrite),
        .ex_ALUsrc(ex_ALUsrc), .ex_regWrite(ex_regWrite), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .bubble_cnt(bubble_cnt)
    );

    // Advance one rising edge and settle outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_memRead = 1'b0; id_memtoReg1 = 1'b0; id_memtoReg2 = 2'b00;
        id_ALUop = 2'b00; id_memWrite = 1'b0; id_ALUsrc = 1'b0; id_regWrite = 1'b0;
        id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_funct3 = 3'd0; id_funct7b5 = 1'b0;
        flush = 1'b0;
    endtask

    // lw rd, imm(rs1)
    task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1);
        idle();
        id_valid = 1'b1; id_memRead = 1'b1; id_memtoReg1 = 1'b1; id_ALUop = 2'b00;
        id_ALUsrc = 1'b1; id_regWrite = 1'b1; id_rs1 = rs1; id_rd = rd;
        id_imm = 32'd4; id_funct3 = 3'b010; id_pc = 32'h200;
    endtask

    // R-type add rd, rs1, rs2
    task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2);
        idle();
        id_valid = 1'b1; id_ALUop = 2'b10; id_regWrite = 1'b1; id_ALUsrc = 1'b0;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_pc = 32'h100;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        id_valid = 1'b1; id_memRead = 1'b1; id_regWrite = 1'b1; id_ALUop = 2'b11;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        id_rd = 5'($urandom_range(1, 31)); id_rs1 = id_rd;
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        checks++; if ({ex_memRead, ex_regWrite, ex_ALUop} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {ex_memRead, ex_regWrite, ex_ALUop}); end
        checks++; if (ex_rs1_data !== 32'd0 || ex_pc !== 32'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%0d exp=0", ex_rs1_data, ex_pc, ex_rd); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL reset_write got=%b%b exp=11", pc_write, ifid_write); end
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_plain_pass();
        drive_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        id_funct3 = 3'b000;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL pass_pc_write got=%b exp=1", pc_write); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_regWrite !== 1'b1 || ex_ALUop !== 2'b10) begin errors++; $display("FAIL pass_ctrl got=v%b rw%b op%b exp=v1 rw1 op10", ex_valid, ex_regWrite, ex_ALUop); end
        checks++; if (ex_rs1_data !== 32'd5 || ex_rs2_data !== 32'd7) begin errors++; $display("FAIL pass_data got=%0d,%0d exp=5,7", ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_rd !== 5'd3 || ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_pc !== 32'h100) begin errors++; $display("FAIL pass_idx got=rd%0d rs1%0d rs2%0d pc%h exp=3,1,2,100", ex_rd, ex_rs1, ex_rs2, ex_pc); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL pass_cnt got=%0d exp=0", bubble_cnt); end
        // Invalid entry: registered with controls forced off, not counted
        drive_add(5'd9, 5'd1, 5'd2, 32'd1, 32'd2);
        id_valid = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_ALUop !== 2'b00 || ex_rd !== 5'd9) begin errors++; $display("FAIL invalid_entry got=v%b rw%b op%b rd%0d exp=v0 rw0 op00 rd9", ex_valid, ex_regWrite, ex_ALUop, ex_rd); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL invalid_cnt got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_load_use();
        drive_lw(5'd5, 5'd2);
        step();
        checks++; if (ex_memRead !== 1'b1 || ex_memtoReg1 !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL lw_in_ex got=mr%b m1%b rd%0d exp=1,1,5", ex_memRead, ex_memtoReg1, ex_rd); end
        drive_add(5'd6, 5'd5, 5'd1, 32'd9, 32'd3);
        #1;
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b%b exp=00", pc_write, ifid_write); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_memRead !== 1'b0) begin errors++; $display("FAIL lu_bubble got=v%b rw%b mr%b exp=000", ex_valid, ex_regWrite, ex_memRead); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", bubble_cnt); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got=%b exp=1", pc_write); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1_data !== 32'd9) begin errors++; $display("FAIL lu_add_arrives got=v%b rd%0d d%0d exp=1,6,9", ex_valid, ex_rd, ex_rs1_data); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt_hold got=%0d exp=1", bubble_cnt); end
        // Store reading the load result via rs2 also stalls
        drive_lw(5'd5, 5'd2);
        step();
        drive_add(5'd0, 5'd1, 5'd5, 32'd0, 32'd0);
        id_ALUsrc = 1'b1; id_memWrite = 1'b1; id_regWrite = 1'b0; id_ALUop = 2'b00;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL store_stall got=%b exp=0", pc_write); end
        step();
        checks++; if (bubble_cnt !== 4'd2) begin errors++; $display("FAIL store_cnt got=%0d exp=2", bubble_cnt); end
        step();
        checks++; if (ex_memWrite !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL store_arrives got=mw%b v%b exp=11", ex_memWrite, ex_valid); end
    endtask

    task automatic test_no_false_stall();
        drive_lw(5'd0, 5'd2);
        step();
        drive_add(5'd6, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL x0_stall got=%b exp=1", pc_write); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL x0_pass got=v%b rd%0d exp=1,6", ex_valid, ex_rd); end
        drive_lw(5'd5, 5'd2);
        step();
        drive_add(5'd7, 5'd1, 5'd5, 32'd11, 32'd0);
        id_ALUsrc = 1'b1; id_ALUop = 2'b00; id_imm = 32'd5;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL addi_stall got=%b%b exp=11", pc_write, ifid_write); end
        step();
        checks++; if (ex_rd !== 5'd7 || ex_ALUsrc !== 1'b1 || ex_imm !== 32'd5) begin errors++; $display("FAIL addi_pass got=rd%0d src%b imm%0d exp=7,1,5", ex_rd, ex_ALUsrc, ex_imm); end
        checks++; if (bubble_cnt !== 4'd2) begin errors++; $display("FAIL nofalse_cnt got=%0d exp=2", bubble_cnt); end
    endtask

    task automatic test_flush_stall();
        drive_lw(5'd5, 5'd2);
        step();
        drive_add(5'd6, 5'd5, 5'd5, 32'd1, 32'd1);
        flush = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL flush_write got=%b%b exp=11", pc_write, ifid_write); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_ALUop !== 2'b00) begin errors++; $display("FAIL flush_bubble got=v%b rw%b op%b exp=0,0,00", ex_valid, ex_regWrite, ex_ALUop); end
        checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL flush_cnt got=%0d exp=3", bubble_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        idle();
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 11) begin
                checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", bubble_cnt); end
            end
        end
        checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", bubble_cnt); end
        // Park a load in EX with a dependent add in ID, then reset mid-stall
        idle();
        drive_lw(5'd5, 5'd2);
        step();
        drive_add(5'd6, 5'd5, 5'd1, 32'd0, 32'd0);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL pre_rst_stall got=%b exp=0", pc_write); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", bubble_cnt); end
        checks++; if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL async_ex got=v%b mr%b rd%0d exp=0,0,0", ex_valid, ex_memRead, ex_rd); end
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL async_write got=%b%b exp=11", pc_write, ifid_write); end
        step();
        rst_n = 1'b1;
        idle();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_plain_pass();
        test_load_use();
        test_no_false_stall();
        test_flush_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
